// File: rtl/uart_loader_pkg.sv
// ---------------------------------------------------------------------------
// uart_loader_pkg
// Shared definitions for the UART boot-time memory loader: FSM state
// encoding, word geometry, and the timer width helper.
// ---------------------------------------------------------------------------
package uart_loader_pkg;

   typedef enum logic [2:0] {
      S_LEN_LO = 3'd0,
      S_LEN_HI = 3'd1,
      S_DATA   = 3'd2,
      S_DONE   = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int ADDR_STEP      = 4;

   // Width needed for a timer that must be able to hold the value 'cycles'.
   function automatic int timer_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/uart_mem_loader_word_assembler.sv
// ---------------------------------------------------------------------------
// word_assembler
// 8->32 little-endian assembler. Bytes shift in from the top so the first
// byte of a word ends up in bits [7:0]. The word and word_valid are
// presented combinationally in the cycle the 4th byte is strobed; the
// caller registers them into its own write stage.
// Ports:
//   i_clk, i_rst   clock, async active-high reset
//   i_clr          drop any partial word, counter back to 0 (wins over i_en)
//   i_en           accept i_byte this cycle
//   i_byte         incoming byte
//   o_word         assembled word (meaningful when o_word_valid=1)
//   o_word_valid   1 in the cycle the 4th byte of a word is accepted
// ---------------------------------------------------------------------------
module word_assembler
   import uart_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_valid
);

   logic [1:0]  r_cnt;
   logic [31:0] r_shift;
   logic        w_take;

   assign w_take       = i_en & ~i_clr;
   assign o_word_valid = w_take & (r_cnt == 2'(BYTES_PER_WORD - 1));
   assign o_word       = {i_byte, r_shift[31:8]};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= 2'd0;
         r_shift <= 32'd0;
      end else if (i_clr) begin
         r_cnt   <= 2'd0;
         r_shift <= 32'd0;
      end else if (w_take) begin
         r_shift <= {i_byte, r_shift[31:8]};
         r_cnt   <= r_cnt + 2'd1;   // wraps 3->0 at the end of each word
      end
   end

endmodule

// File: rtl/uart_mem_loader.sv
// ---------------------------------------------------------------------------
// uart_mem_loader
// Boot-time loader: receives LEN_LO, LEN_HI (word count N) then N*4 bytes
// and writes little-endian words through the CPU external memory port while
// holding the CPU in reset. Releases the CPU once all N words are written.
// Ports:
//   clk, reset      system clock, async active-high reset
//   rx_data         received byte, qualified by rx_valid
//   rx_valid        one-cycle strobe per byte, always consumed
//   load_req        one-cycle pulse: abort and restart loading
//   cpu_reset       CPU reset, 1 unless the image is completely loaded
//   Ext_MemWrite    one-cycle write strobe
//   Ext_WriteData   assembled word
//   Ext_DataAdr     byte address of the current word
//   load_done       level, image loaded
//   load_err        level, length or timeout error
//   words_loaded    words written in the current frame
// ---------------------------------------------------------------------------
module uart_mem_loader
   import uart_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          MAX_WORDS      = 64,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        load_req,
   output logic        cpu_reset,
   output logic        Ext_MemWrite,
   output logic [31:0] Ext_WriteData,
   output logic [31:0] Ext_DataAdr,
   output logic        load_done,
   output logic        load_err,
   output logic [15:0] words_loaded
);

   localparam int TW = timer_width(TIMEOUT_CYCLES);

   state_t        r_state, w_next;
   logic [7:0]    r_len_lo;
   logic [15:0]   r_len;
   logic [TW-1:0] r_timer;
   logic          r_memwrite;
   logic [31:0]   r_wdata;
   logic [31:0]   r_adr;
   logic [15:0]   r_words;

   logic [15:0]   w_n;
   logic          w_timeout;
   logic          w_last_wr;
   logic          w_timed;
   logic          w_asm_clr;
   logic          w_asm_en;
   logic [31:0]   w_word;
   logic          w_word_valid;

   assign w_n       = {rx_data, r_len_lo};
   assign w_timed   = (r_state == S_LEN_HI) || (r_state == S_DATA);
   assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES));
   // The write currently on the bus is the N-th one of the frame.
   assign w_last_wr = r_memwrite && ((r_words + 16'd1) == r_len);

   // Assembler only runs in DATA; leaving DATA (or a restart) drops any
   // partial word so it can never be written later.
   assign w_asm_clr = load_req || (r_state != S_DATA);
   assign w_asm_en  = rx_valid && (r_state == S_DATA);

   word_assembler u_asm (
      .i_clk        (clk),
      .i_rst        (reset),
      .i_clr        (w_asm_clr),
      .i_en         (w_asm_en),
      .i_byte       (rx_data),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_LEN_LO;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (load_req) begin
         w_next = S_LEN_LO;
      end else begin
         case (r_state)
            S_LEN_LO: if (rx_valid) w_next = S_LEN_HI;
            S_LEN_HI: begin
               if (rx_valid) begin
                  if (w_n > 16'(MAX_WORDS)) w_next = S_ERR;
                  else if (w_n == 16'd0)    w_next = S_DONE;
                  else                      w_next = S_DATA;
               end else if (w_timeout) begin
                  w_next = S_ERR;
               end
            end
            S_DATA: begin
               // Completion takes priority; DONE lands the cycle after the
               // last write pulse so cpu_reset never drops during a write.
               if (w_last_wr)                   w_next = S_DONE;
               else if (!rx_valid && w_timeout) w_next = S_ERR;
            end
            S_DONE:  w_next = S_DONE;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_LEN_LO;
         endcase
      end
   end

   // ---------------- inter-byte timer ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer <= '0;
      end else if (rx_valid || (w_next != r_state) || !w_timed) begin
         r_timer <= '0;
      end else if (!w_timeout) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // ---------------- length, write stage, address ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_len_lo   <= 8'd0;
         r_len      <= 16'd0;
         r_memwrite <= 1'b0;
         r_wdata    <= 32'd0;
         r_adr      <= BASE_ADDR;
         r_words    <= 16'd0;
      end else if (load_req) begin
         // Cancels a write pulse that would otherwise fire next cycle.
         r_memwrite <= 1'b0;
         r_adr      <= BASE_ADDR;
         r_words    <= 16'd0;
      end else begin
         if ((r_state == S_LEN_LO) && rx_valid) r_len_lo <= rx_data;
         if ((r_state == S_LEN_HI) && rx_valid) r_len    <= w_n;

         // Separate write register: the assembler is free to take the next
         // byte during the write cycle.
         r_memwrite <= w_word_valid;
         if (w_word_valid) r_wdata <= w_word;

         // Address/count advance the cycle after the pulse, so the address
         // is stable for the whole write cycle.
         if (r_memwrite) begin
            r_adr   <= r_adr + 32'(ADDR_STEP);
            r_words <= r_words + 16'd1;
         end
      end
   end

   assign cpu_reset     = (r_state != S_DONE);
   assign load_done     = (r_state == S_DONE);
   assign load_err      = (r_state == S_ERR);
   assign Ext_MemWrite  = r_memwrite;
   assign Ext_WriteData = r_wdata;
   assign Ext_DataAdr   = r_adr;
   assign words_loaded  = r_words;

endmodule

// File: tb/tb_uart_mem_loader.sv
module tb_uart_mem_loader;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int MAXW = 64;
   localparam int TMO  = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        load_req;
   logic        cpu_reset;
   logic        Ext_MemWrite;
   logic [31:0] Ext_WriteData;
   logic [31:0] Ext_DataAdr;
   logic        load_done;
   logic        load_err;
   logic [15:0] words_loaded;

   always #5 clk = ~clk;

   uart_mem_loader #(
      .BASE_ADDR      (BASE),
      .MAX_WORDS      (MAXW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .load_req      (load_req),
      .cpu_reset     (cpu_reset),
      .Ext_MemWrite  (Ext_MemWrite),
      .Ext_WriteData (Ext_WriteData),
      .Ext_DataAdr   (Ext_DataAdr),
      .load_done     (load_done),
      .load_err      (load_err),
      .words_loaded  (words_loaded)
   );

   typedef struct {
      string        name;
      int           nb;
      logic [127:0] b;      // byte i at bits [8*i +: 8]
      int           gap;
      logic         done;
      logic         err;
      logic [15:0]  words;
      logic [31:0]  adr;
   } vec_t;

   vec_t        vt[6];
   logic [63:0] sbq[$];     // {addr, data} expected writes, in order
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every write pulse must match the oldest expected write.
   task automatic mon();
      logic [63:0] e;
      if (Ext_MemWrite === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: adr %h data %h, expected no write", Ext_DataAdr, Ext_WriteData);
         end else begin
            e = sbq.pop_front();
            chk("wr_adr", Ext_DataAdr, e[63:32]);
            chk("wr_data", Ext_WriteData, e[31:0]);
            chk("wr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      mon();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      repeat (gap) step();
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      step();
      load_req = 1'b0;
   endtask

   // Sends the first nb bytes; expected writes are derived from the bytes.
   task automatic send_frame(input logic [127:0] b, input int nb, input int gap);
      int n;
      int d;
      n = int'({b[15:8], b[7:0]});
      for (int i = 0; i < nb; i++) begin
         d = i - 2;
         if (d >= 0 && n <= MAXW && (d % 4) == 3 && (d / 4) < n)
            sbq.push_back({BASE + 32'(4 * (d / 4)), b[8*i +: 8], b[8*(i-1) +: 8], b[8*(i-2) +: 8], b[8*(i-3) +: 8]});
         send_byte(b[8*i +: 8], gap);
      end
   endtask

   initial begin
      int k;
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      load_req = 1'b0;

      vt[0] = '{"t1_two_words", 10, 128'hDEADBEEF_12345678_0002, 2, 1'b1, 1'b0, 16'd2, BASE + 32'd8};
      vt[1] = '{"t2_zero_len",   2, 128'h0000,                   1, 1'b1, 1'b0, 16'd0, BASE};
      vt[2] = '{"t3_too_long",   2, 128'h0041,                   1, 1'b0, 1'b1, 16'd0, BASE};
      vt[3] = '{"t3_reload",    10, 128'hDEADBEEF_12345678_0002, 0, 1'b1, 1'b0, 16'd2, BASE + 32'd8};
      vt[4] = '{"t5_b2b_n3",    14, 128'h0C0B0A09_08070605_04030201_0003, 0, 1'b1, 1'b0, 16'd3, BASE + 32'd12};
      vt[5] = '{"n1_gap3",       6, 128'h44332211_0001,          3, 1'b1, 1'b0, 16'd1, BASE + 32'd4};

      // reset state
      repeat (3) step();
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("rst_memwrite", {31'd0, Ext_MemWrite}, 32'd0);
      chk("rst_wdata", Ext_WriteData, 32'd0);
      chk("rst_adr", Ext_DataAdr, BASE);
      chk("rst_done", {31'd0, load_done}, 32'd0);
      chk("rst_err", {31'd0, load_err}, 32'd0);
      chk("rst_words", {16'd0, words_loaded}, 32'd0);
      reset = 1'b0;
      step();

      // table-driven frames
      for (int v = 0; v < 6; v++) begin
         pulse_load();
         chk({vt[v].name, "_start_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
         send_frame(vt[v].b, vt[v].nb, vt[v].gap);
         repeat (3) step();
         chk({vt[v].name, "_done"}, {31'd0, load_done}, {31'd0, vt[v].done});
         chk({vt[v].name, "_err"}, {31'd0, load_err}, {31'd0, vt[v].err});
         chk({vt[v].name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~vt[v].done});
         chk({vt[v].name, "_words"}, {16'd0, words_loaded}, {16'd0, vt[v].words});
         chk({vt[v].name, "_adr"}, Ext_DataAdr, vt[v].adr);
         chk({vt[v].name, "_sb_empty"}, sbq.size(), 32'd0);
      end

      // exact release timing: cpu_reset falls the cycle after the last write
      pulse_load();
      send_frame(vt[0].b, 9, 1);
      sbq.push_back({BASE + 32'd4, 32'hDEADBEEF});
      send_byte(8'hDE, 0);
      chk("t1x_wr_pulse", {31'd0, Ext_MemWrite}, 32'd1);
      chk("t1x_wr_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("t1x_wr_done", {31'd0, load_done}, 32'd0);
      step();
      chk("t1x_rel_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      chk("t1x_rel_done", {31'd0, load_done}, 32'd1);
      chk("t1x_rel_words", {16'd0, words_loaded}, 32'd2);
      chk("t1x_rel_memwrite", {31'd0, Ext_MemWrite}, 32'd0);

      // N=0: DONE the cycle after LEN_HI
      pulse_load();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("t2x_done", {31'd0, load_done}, 32'd1);
      chk("t2x_cpu_reset", {31'd0, cpu_reset}, 32'd0);

      // timeout with a partial word pending
      pulse_load();
      send_frame(128'hBBAA_0001, 4, 0);
      k = 0;
      while (!load_err && k < TMO + 20) begin
         step();
         k++;
      end
      chk("t4_err", {31'd0, load_err}, 32'd1);
      chk("t4_window", {31'd0, (k >= TMO && k <= TMO + 3)}, 32'd1);
      chk("t4_words", {16'd0, words_loaded}, 32'd0);
      chk("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);

      // N == MAX_WORDS is accepted
      pulse_load();
      send_byte(8'(MAXW), 0);
      send_byte(8'h00, 0);
      for (int w = 0; w < MAXW; w++) begin
         sbq.push_back({BASE + 32'(4 * w), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
         for (int j = 0; j < 4; j++) send_byte(8'(4 * w + j), 0);
      end
      repeat (3) step();
      chk("max_done", {31'd0, load_done}, 32'd1);
      chk("max_words", {16'd0, words_loaded}, 32'(MAXW));
      chk("max_adr", Ext_DataAdr, BASE + 32'(4 * MAXW));

      // load_req and rx_valid together: byte is dropped
      load_req = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h05;
      step();
      load_req = 1'b0;
      rx_valid = 1'b0;
      chk("lrq_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("lrq_done", {31'd0, load_done}, 32'd0);
      chk("lrq_words", {16'd0, words_loaded}, 32'd0);
      chk("lrq_adr", Ext_DataAdr, BASE);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("lrq_drop_done", {31'd0, load_done}, 32'd1);

      // load_req on the 4th byte of a word: no write
      pulse_load();
      send_frame(128'h332211_0001, 5, 0);
      load_req = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h44;
      step();
      load_req = 1'b0;
      rx_valid = 1'b0;
      step();
      step();
      chk("cancel_words", {16'd0, words_loaded}, 32'd0);
      chk("cancel_cpu_reset", {31'd0, cpu_reset}, 32'd1);

      // async reset mid-DATA, then a full resend
      pulse_load();
      send_frame(vt[0].b, 6, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("t6_memwrite", {31'd0, Ext_MemWrite}, 32'd0);
      chk("t6_wdata", Ext_WriteData, 32'd0);
      chk("t6_adr", Ext_DataAdr, BASE);
      chk("t6_words", {16'd0, words_loaded}, 32'd0);
      chk("t6_done", {31'd0, load_done}, 32'd0);
      step();
      step();
      reset = 1'b0;
      send_frame(vt[0].b, 10, 0);
      repeat (3) step();
      chk("t6_reload_done", {31'd0, load_done}, 32'd1);
      chk("t6_reload_words", {16'd0, words_loaded}, 32'd2);
      pulse_load();
      chk("t6_lrq_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("t6_lrq_done", {31'd0, load_done}, 32'd0);

      chk("sb_final_empty", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net against a hung run.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: sim time expired, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
